control_flujo_fsm: RTL and testbench

//  Sequences the VC0/VC1 -> D0/D1 routing arbiter and configures its FIFOs.

---
 rtl/fc_pkg.sv | 31 +++
 rtl/umbrales_reg.sv | 62 ++++++
 rtl/control_flujo_fsm.sv | 160 ++++++++++++++++
 tb/tb_control_flujo_fsm.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// -----------------------------------------------------------------------------
// fc_pkg
//   Shared definitions for the flow-control sequencer (control_flujo_fsm) and
//   its threshold register block (umbrales_reg).
//
//   Contents:
//     estado_e       3-bit state encoding. The numeric codes are visible on
//                    the debug port, so they must not be reordered.
//     FC_NUM_FIFOS   default number of monitored FIFOs, bit order {D1,D0,VC1,VC0}
//     FC_TH_W        default threshold width, in words
//     FC_DEPTH       default FIFO depth; upper bound for the almost-full level
//     FC_DEF_ALTO    almost-full threshold loaded by reset
//     FC_DEF_BAJO    almost-empty threshold loaded by reset
// -----------------------------------------------------------------------------
package fc_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } estado_e;

    localparam int FC_NUM_FIFOS = 4;
    localparam int FC_TH_W      = 4;
    localparam int FC_DEPTH     = 8;
    localparam int FC_DEF_ALTO  = 6;
    localparam int FC_DEF_BAJO  = 1;

endpackage : fc_pkg

// File: rtl/umbrales_reg.sv
// -----------------------------------------------------------------------------
// umbrales_reg
//   Holds the active almost-full / almost-empty threshold pair that is fed to
//   the FIFOs. A candidate pair is loaded only when the sequencer enables the
//   load and the pair is coherent: bajo < alto and alto <= DEPTH. An
//   incoherent pair is silently ignored and the previous pair is kept.
//
//   Ports:
//     clk        in   1      rising-edge clock
//     reset      in   1      synchronous, active-high; restores the defaults
//     load_en_i  in   1      load window (the sequencer is configuring)
//     alto_i     in   TH_W   candidate almost-full threshold
//     bajo_i     in   TH_W   candidate almost-empty threshold
//     alto_o     out  TH_W   active almost-full threshold
//     bajo_o     out  TH_W   active almost-empty threshold
// -----------------------------------------------------------------------------
module umbrales_reg
    import fc_pkg::*;
#(
    parameter int TH_W     = FC_TH_W,
    parameter int DEPTH    = FC_DEPTH,
    parameter int DEF_ALTO = FC_DEF_ALTO,
    parameter int DEF_BAJO = FC_DEF_BAJO
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_en_i,
    input  logic [TH_W-1:0] alto_i,
    input  logic [TH_W-1:0] bajo_i,
    output logic [TH_W-1:0] alto_o,
    output logic [TH_W-1:0] bajo_o
);

    // One extra bit so DEPTH itself is representable even when it equals
    // 2**TH_W, keeping the compare free of truncation.
    localparam logic [TH_W:0] DEPTH_C = (TH_W+1)'(DEPTH);

    logic [TH_W-1:0] alto_q;
    logic [TH_W-1:0] bajo_q;
    logic            par_valido;

    // An almost-empty level at or above the almost-full level would make
    // the two FIFO flags overlap, and an almost-full level above the depth
    // could never be reached.
    assign par_valido = (bajo_i < alto_i) && ({1'b0, alto_i} <= DEPTH_C);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            alto_q <= TH_W'(DEF_ALTO);
            bajo_q <= TH_W'(DEF_BAJO);
        end else if (load_en_i && par_valido) begin
            alto_q <= alto_i;
            bajo_q <= bajo_i;
        end
    end

    assign alto_o = alto_q;
    assign bajo_o = bajo_q;

endmodule : umbrales_reg

// File: rtl/control_flujo_fsm.sv
// -----------------------------------------------------------------------------
// control_flujo_fsm
//   Sequencer for the VC0/VC1 -> D0/D1 routing arbiter. Walks
//   RESET -> INIT -> IDLE/ACTIVE, lets the FIFO thresholds be configured
//   while in INIT, gates arbiter traffic through arb_enable and locks into
//   ERROR on any FIFO overflow/underflow until reset.
//
//   Ports:
//     clk             in   1          rising-edge clock
//     reset           in   1          synchronous, active-high
//     init            in   1          request (re)configuration
//     umbral_alto_in  in   TH_W       candidate almost-full threshold
//     umbral_bajo_in  in   TH_W       candidate almost-empty threshold
//     fifo_empty      in   NUM_FIFOS  per-FIFO empty flag {D1,D0,VC1,VC0}
//     fifo_error      in   NUM_FIFOS  per-FIFO overflow/underflow pulse
//     umbral_alto     out  TH_W       active almost-full threshold
//     umbral_bajo     out  TH_W       active almost-empty threshold
//     arb_enable      out  1          arbiter may pop/push (ACTIVE only)
//     active_out      out  1          state is ACTIVE
//     idle_out        out  1          state is IDLE
//     error_out       out  1          state is ERROR
//     error_vec       out  NUM_FIFOS  sticky record of FIFOs that errored
//     estado          out  3          current state code, for debug
//
//   All outputs are registered Moore outputs: they are computed from the
//   next state and captured on the same edge as the state register, so they
//   always agree with estado and never glitch.
// -----------------------------------------------------------------------------
module control_flujo_fsm
    import fc_pkg::*;
#(
    parameter int NUM_FIFOS = FC_NUM_FIFOS,
    parameter int TH_W      = FC_TH_W,
    parameter int DEPTH     = FC_DEPTH,
    parameter int DEF_ALTO  = FC_DEF_ALTO,
    parameter int DEF_BAJO  = FC_DEF_BAJO
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [TH_W-1:0]      umbral_alto_in,
    input  logic [TH_W-1:0]      umbral_bajo_in,
    input  logic [NUM_FIFOS-1:0] fifo_empty,
    input  logic [NUM_FIFOS-1:0] fifo_error,
    output logic [TH_W-1:0]      umbral_alto,
    output logic [TH_W-1:0]      umbral_bajo,
    output logic                 arb_enable,
    output logic                 active_out,
    output logic                 idle_out,
    output logic                 error_out,
    output logic [NUM_FIFOS-1:0] error_vec,
    output logic [2:0]           estado
);

    estado_e              estado_q;
    estado_e              estado_d;
    logic                 arb_enable_q;
    logic                 active_q;
    logic                 idle_q;
    logic                 error_q;
    logic [NUM_FIFOS-1:0] error_vec_q;

    logic hay_error;
    logic todas_vacias;

    assign hay_error    = |fifo_error;
    assign todas_vacias = &fifo_empty;

    // -------------------------------------------------------------------------
    // Next-state logic. Error always has top priority, so a simultaneous
    // error and init request lands in ERROR.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns estado_d and no latch
        // is inferred.
        estado_d = ST_RESET;
        unique case (estado_q)
            ST_RESET: estado_d = ST_INIT;

            ST_INIT: begin
                if (hay_error)  estado_d = ST_ERROR;
                else if (!init) estado_d = ST_IDLE;
                else            estado_d = ST_INIT;
            end

            ST_IDLE: begin
                if (hay_error)          estado_d = ST_ERROR;
                else if (init)          estado_d = ST_INIT;
                else if (!todas_vacias) estado_d = ST_ACTIVE;
                else                    estado_d = ST_IDLE;
            end

            ST_ACTIVE: begin
                if (hay_error)         estado_d = ST_ERROR;
                else if (init)         estado_d = ST_INIT;
                else if (todas_vacias) estado_d = ST_IDLE;
                else                   estado_d = ST_ACTIVE;
            end

            ST_ERROR: estado_d = ST_ERROR;

            // Unused codes fall back to RESET so a corrupted state register
            // recovers through a full reconfiguration.
            default: estado_d = ST_RESET;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register plus registered output decode.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q     <= ST_RESET;
            arb_enable_q <= 1'b0;
            active_q     <= 1'b0;
            idle_q       <= 1'b0;
            error_q      <= 1'b0;
            error_vec_q  <= '0;
        end else begin
            estado_q     <= estado_d;
            // The arbiter is cut off the first cycle outside ACTIVE; any word
            // it was moving is not completed.
            arb_enable_q <= (estado_d == ST_ACTIVE);
            active_q     <= (estado_d == ST_ACTIVE);
            idle_q       <= (estado_d == ST_IDLE);
            error_q      <= (estado_d == ST_ERROR);
            // Accumulate from the entry edge on, so the bits that caused the
            // error are captured together with any that arrive later.
            if (estado_d == ST_ERROR) begin
                error_vec_q <= error_vec_q | fifo_error;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Threshold registers: loadable only while configuring.
    // -------------------------------------------------------------------------
    umbrales_reg #(
        .TH_W     (TH_W),
        .DEPTH    (DEPTH),
        .DEF_ALTO (DEF_ALTO),
        .DEF_BAJO (DEF_BAJO)
    ) u_umbrales (
        .clk       (clk),
        .reset     (reset),
        .load_en_i (estado_q == ST_INIT),
        .alto_i    (umbral_alto_in),
        .bajo_i    (umbral_bajo_in),
        .alto_o    (umbral_alto),
        .bajo_o    (umbral_bajo)
    );

    assign estado     = estado_q;
    assign arb_enable = arb_enable_q;
    assign active_out = active_q;
    assign idle_out   = idle_q;
    assign error_out  = error_q;
    assign error_vec  = error_vec_q;

endmodule : control_flujo_fsm

// File: tb/tb_control_flujo_fsm.sv
// -----------------------------------------------------------------------------
// tb_control_flujo_fsm
//   Directed bench for control_flujo_fsm. A behavioural model tracks the
//   expected state code, thresholds and sticky error record from the
//   sequencing rules; a compare process checks every DUT output against it
//   each cycle, and the stimulus pins key points with literal expectations.
// -----------------------------------------------------------------------------
module tb_control_flujo_fsm;

    localparam int NF = 4;
    localparam int TW = 4;

    // State codes as seen on the debug port.
    localparam int C_RESET  = 0;
    localparam int C_INIT   = 1;
    localparam int C_IDLE   = 2;
    localparam int C_ACTIVE = 3;
    localparam int C_ERROR  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic [TW-1:0] umbral_alto_in;
    logic [TW-1:0] umbral_bajo_in;
    logic [NF-1:0] fifo_empty;
    logic [NF-1:0] fifo_error;
    logic [TW-1:0] umbral_alto;
    logic [TW-1:0] umbral_bajo;
    logic          arb_enable;
    logic          active_out;
    logic          idle_out;
    logic          error_out;
    logic [NF-1:0] error_vec;
    logic [2:0]    estado;

    always #5 clk = ~clk;

    control_flujo_fsm #(
        .NUM_FIFOS (NF),
        .TH_W      (TW),
        .DEPTH     (8),
        .DEF_ALTO  (6),
        .DEF_BAJO  (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .init           (init),
        .umbral_alto_in (umbral_alto_in),
        .umbral_bajo_in (umbral_bajo_in),
        .fifo_empty     (fifo_empty),
        .fifo_error     (fifo_error),
        .umbral_alto    (umbral_alto),
        .umbral_bajo    (umbral_bajo),
        .arb_enable     (arb_enable),
        .active_out     (active_out),
        .idle_out       (idle_out),
        .error_out      (error_out),
        .error_vec      (error_vec),
        .estado         (estado)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model, advanced on every rising edge from sampled inputs.
    // -------------------------------------------------------------------------
    int m_st    = C_RESET;
    int m_alto  = 0;
    int m_bajo  = 0;
    int m_vec   = 0;
    bit m_known = 1'b0;

    initial begin
        forever begin
            int err;
            int a;
            int b;
            bit all_empty;
            @(posedge clk);
            err       = int'(fifo_error);
            a         = int'(umbral_alto_in);
            b         = int'(umbral_bajo_in);
            all_empty = (fifo_empty == 4'hF);
            if (reset) begin
                m_st    = C_RESET;
                m_alto  = 6;
                m_bajo  = 1;
                m_vec   = 0;
                m_known = 1'b1;
            end else if (m_known) begin
                if (m_st == C_INIT && b < a && a <= 8) begin
                    m_alto = a;
                    m_bajo = b;
                end
                if (m_st == C_RESET)                 m_st = C_INIT;
                else if (m_st == C_ERROR)            m_st = C_ERROR;
                else if (err != 0)                   m_st = C_ERROR;
                else if (m_st == C_INIT)             m_st = init ? C_INIT : C_IDLE;
                else if (init)                       m_st = C_INIT;
                else if (m_st == C_IDLE)             m_st = all_empty ? C_IDLE : C_ACTIVE;
                else                                 m_st = all_empty ? C_IDLE : C_ACTIVE;
                if (m_st == C_ERROR) m_vec = m_vec | err;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-cycle comparison, sampled mid-cycle away from the rising edge.
    // -------------------------------------------------------------------------
    initial begin
        forever begin
            int exp_flags;
            @(negedge clk);
            #1;
            if (m_known) begin
                exp_flags = ((m_st == C_ACTIVE) ? 8 : 0) + ((m_st == C_ACTIVE) ? 4 : 0)
                          + ((m_st == C_IDLE) ? 2 : 0) + ((m_st == C_ERROR) ? 1 : 0);
                check("model_estado", 32'(estado), 32'(m_st));
                check("model_flags", 32'({arb_enable, active_out, idle_out, error_out}), 32'(exp_flags));
                check("model_umbrales", 32'({umbral_alto, umbral_bajo}), 32'(m_alto * 16 + m_bajo));
                check("model_error_vec", 32'(error_vec), 32'(m_vec));
            end
        end
    end

    // Advance one clock; returns after the compare process has sampled.
    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    function automatic logic [31:0] flags();
        return 32'({arb_enable, active_out, idle_out, error_out});
    endfunction

    // -------------------------------------------------------------------------
    // Directed stimulus with literal expectations.
    // -------------------------------------------------------------------------
    initial begin
        reset          = 1'b1;
        init           = 1'b0;
        umbral_alto_in = '0;
        umbral_bajo_in = '0;
        fifo_empty     = 4'hF;
        fifo_error     = '0;

        // Reset state.
        cyc(); cyc();
        check("rst_estado", 32'(estado), 0);
        check("rst_flags", flags(), 0);
        check("rst_error_vec", 32'(error_vec), 0);
        check("rst_umbrales", 32'({umbral_alto, umbral_bajo}), 32'h61);

        reset = 1'b0;
        cyc();
        check("reset_to_init", 32'(estado), 1);

        // Valid pair loaded while configuring.
        init = 1'b1; umbral_alto_in = 4'd5; umbral_bajo_in = 4'd2;
        cyc(); cyc();
        check("load_pair", 32'({umbral_alto, umbral_bajo}), 32'h52);
        check("init_hold", 32'(estado), 1);
        init = 1'b0;
        cyc();
        check("init_to_idle", 32'(estado), 2);
        check("idle_flags", flags(), 32'b0010);

        // Threshold boundaries from fresh defaults.
        reset = 1'b1; cyc();
        reset = 1'b0; cyc();
        init = 1'b1; umbral_alto_in = 4'd2; umbral_bajo_in = 4'd3;
        cyc();
        check("inv_order", 32'({umbral_alto, umbral_bajo}), 32'h61);
        umbral_alto_in = 4'd4; umbral_bajo_in = 4'd4;
        cyc();
        check("inv_equal", 32'({umbral_alto, umbral_bajo}), 32'h61);
        umbral_alto_in = 4'd9; umbral_bajo_in = 4'd1;
        cyc();
        check("inv_depth", 32'({umbral_alto, umbral_bajo}), 32'h61);
        umbral_alto_in = 4'd8; umbral_bajo_in = 4'd7;
        cyc();
        check("max_depth", 32'({umbral_alto, umbral_bajo}), 32'h87);
        init = 1'b0; umbral_alto_in = 4'd2; umbral_bajo_in = 4'd3;
        cyc();
        check("inv_keep", 32'({umbral_alto, umbral_bajo}), 32'h87);
        check("inv_to_idle", 32'(estado), 2);

        // IDLE <-> ACTIVE on the empty flags.
        cyc();
        check("idle_all_empty", 32'(estado), 2);
        fifo_empty = 4'b1101;
        cyc();
        check("to_active", 32'(estado), 3);
        check("active_flags", flags(), 32'b1100);
        cyc();
        check("active_hold", 32'(estado), 3);
        fifo_empty = 4'hF;
        cyc();
        check("back_idle", 32'(estado), 2);
        check("arb_drop", 32'(arb_enable), 0);

        // init from ACTIVE reconfigures; no load on the leaving edge.
        fifo_empty = 4'b1101;
        cyc();
        init = 1'b1; umbral_alto_in = 4'd7; umbral_bajo_in = 4'd0;
        cyc();
        check("active_to_init", 32'(estado), 1);
        check("active_to_init_umb", 32'({umbral_alto, umbral_bajo}), 32'h87);
        init = 1'b0; umbral_alto_in = 4'd0; umbral_bajo_in = 4'd0; fifo_empty = 4'hF;
        cyc();
        check("reinit_idle", 32'(estado), 2);

        // Error beats init; sticky accumulation; absorbing.
        fifo_empty = 4'b1101;
        cyc();
        fifo_error = 4'b0100; init = 1'b1;
        cyc();
        check("err_enter", 32'(estado), 4);
        check("err_flags", flags(), 32'b0001);
        check("err_vec_cause", 32'(error_vec), 32'b0100);
        fifo_error = 4'b0001; init = 1'b0;
        cyc();
        check("err_vec_accum", 32'(error_vec), 32'b0101);
        fifo_error = '0; init = 1'b1; umbral_alto_in = 4'd5; umbral_bajo_in = 4'd2;
        cyc();
        init = 1'b0;
        cyc();
        check("err_absorb", 32'(estado), 4);
        check("err_umb_stable", 32'({umbral_alto, umbral_bajo}), 32'h87);

        // Reset out of ERROR, then error from IDLE.
        reset = 1'b1; umbral_alto_in = 4'd0; umbral_bajo_in = 4'd0; fifo_empty = 4'hF;
        cyc();
        check("err_reset_vec", 32'(error_vec), 0);
        reset = 1'b0;
        cyc(); cyc();
        fifo_error = 4'b1000;
        cyc();
        check("idle_err_vec", 32'(error_vec), 32'b1000);
        fifo_error = '0;

        // Reset in the middle of ACTIVE.
        reset = 1'b1; cyc();
        reset = 1'b0; cyc(); cyc();
        fifo_empty = 4'b1101;
        cyc();
        check("pre_reset_active", 32'(estado), 3);
        reset = 1'b1;
        cyc();
        check("mid_reset_estado", 32'(estado), 0);
        check("mid_reset_arb", 32'(arb_enable), 0);
        check("mid_reset_umb", 32'({umbral_alto, umbral_bajo}), 32'h61);
        reset = 1'b0;
        cyc();
        check("mid_reset_init", 32'(estado), 1);

        // Error while configuring, with init still asserted.
        fifo_error = 4'b0010; init = 1'b1;
        cyc();
        check("init_err", 32'(estado), 4);
        check("init_err_vec", 32'(error_vec), 32'b0010);
        fifo_error = '0; init = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_control_flujo_fsm
